// File: rtl/mips_cpu.sv
// Single-cycle MIPS subset: unified word memory, 32x32 register file, one instruction per clock.
// Define CPU_LOGIC_OPS_EN to add and/or/andi/ori.
module mips_cpu #(
    parameter int unsigned MEM_WORDS = 16384,
    parameter logic [31:0] SP_INIT   = 32'h0000FFFC
) (
    input logic clk,
    input logic reset
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0] mem  [MEM_WORDS];
    logic [31:0] regs [32];

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] ea;
    logic [31:0] ld_val;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] next_pc;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        we;
    logic        mem_we;
    logic        unused_ea;

    assign instr      = mem[pc[AW+1:2]];
    assign op         = instr[31:26];
    assign rs         = instr[25:21];
    assign rt         = instr[20:16];
    assign rd         = instr[15:11];
    assign funct      = instr[5:0];
    assign rs_val     = regs[rs];
    assign rt_val     = regs[rt];
    assign imm_sext   = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext   = {16'd0, instr[15:0]};
    assign ea         = rs_val + imm_sext;
    assign ld_val     = mem[ea[AW+1:2]];
    assign pc_plus4   = pc + 32'd4;
    assign br_target  = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jmp_target = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign unused_ea  = ^{ea[31:AW+2], ea[1:0]};

    // Decode: register write, memory write and next PC for the current instruction
    always_comb begin
        we      = 1'b0;
        wa      = 5'd0;
        wd      = 32'd0;
        mem_we  = 1'b0;
        next_pc = pc_plus4;
        case (op)
            6'h00: begin
                wa = rd;
                case (funct)
                    6'h20: begin we = 1'b1; wd = rs_val + rt_val; end
                    6'h22: begin we = 1'b1; wd = rs_val - rt_val; end
                    6'h2A: begin we = 1'b1; wd = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
                    6'h08: next_pc = rs_val;
`ifdef CPU_LOGIC_OPS_EN
                    6'h24: begin we = 1'b1; wd = rs_val & rt_val; end
                    6'h25: begin we = 1'b1; wd = rs_val | rt_val; end
`endif
                    default: ;
                endcase
            end
            6'h08: begin we = 1'b1; wa = rt; wd = rs_val + imm_sext; end
            6'h0E: begin we = 1'b1; wa = rt; wd = rs_val ^ imm_zext; end
`ifdef CPU_LOGIC_OPS_EN
            6'h0C: begin we = 1'b1; wa = rt; wd = rs_val & imm_zext; end
            6'h0D: begin we = 1'b1; wa = rt; wd = rs_val | imm_zext; end
`endif
            6'h23: begin we = 1'b1; wa = rt; wd = ld_val; end
            6'h2B: mem_we = 1'b1;
            6'h04: if (rs_val == rt_val) next_pc = br_target;
            6'h05: if (rs_val != rt_val) next_pc = br_target;
            6'h02: next_pc = jmp_target;
            6'h03: begin we = 1'b1; wa = 5'd31; wd = pc_plus4; next_pc = jmp_target; end
            default: ;
        endcase
    end

    // PC and register file; r0 is never written so it always reads zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 29) ? SP_INIT : 32'd0;
            end
        end else begin
            pc <= next_pc;
            if (we && (wa != 5'd0)) begin
                regs[wa] <= wd;
            end
        end
    end

    // Memory keeps its contents across reset; stores are blocked while reset is held
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[ea[AW+1:2]] <= rt_val;
        end
    end

endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu: directed vector table, hand sequences, and random
// programs compared against an instruction-level reference model.
module tb_mips_cpu;
    localparam int MEMW = 16384;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] m_mem  [MEMW];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] prog [$];

    mips_cpu dut (.clk(clk), .reset(reset));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] a;
        logic [15:0] b;
        int          chk;
        logic [31:0] exp_val;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    function automatic void m_wr(input int r, input logic [31:0] v);
        if (r != 0) m_regs[r] = v;
    endfunction

    // Architectural reference: one instruction per call
    function automatic void model_step();
        logic [31:0] ins, a, b, si, zi, ea, npc;
        int op, fn, rs, rt, rd;
        ins = m_mem[m_pc[15:2]];
        op  = int'(ins[31:26]);
        rs  = int'(ins[25:21]);
        rt  = int'(ins[20:16]);
        rd  = int'(ins[15:11]);
        fn  = int'(ins[5:0]);
        a   = m_regs[rs];
        b   = m_regs[rt];
        si  = 32'($signed(ins[15:0]));
        zi  = {16'd0, ins[15:0]};
        ea  = a + si;
        npc = m_pc + 32'd4;
        case (op)
            0: begin
                if (fn == 32) m_wr(rd, a + b);
                else if (fn == 34) m_wr(rd, a - b);
                else if (fn == 42) m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                else if (fn == 8) npc = a;
`ifdef CPU_LOGIC_OPS_EN
                else if (fn == 36) m_wr(rd, a & b);
                else if (fn == 37) m_wr(rd, a | b);
`endif
            end
            8:  m_wr(rt, a + si);
            14: m_wr(rt, a ^ zi);
`ifdef CPU_LOGIC_OPS_EN
            12: m_wr(rt, a & zi);
            13: m_wr(rt, a | zi);
`endif
            35: m_wr(rt, m_mem[ea[15:2]]);
            43: m_mem[ea[15:2]] = b;
            4:  if (a == b) npc = m_pc + 32'd4 + (si << 2);
            5:  if (a != b) npc = m_pc + 32'd4 + (si << 2);
            2:  npc = {npc[31:28], ins[25:0], 2'b00};
            3:  begin m_wr(31, m_pc + 32'd4); npc = {npc[31:28], ins[25:0], 2'b00}; end
            default: ;
        endcase
        m_pc = npc;
    endfunction

    function automatic void model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'h0000FFFC : 32'd0;
    endfunction

    // Hold reset across one edge, load prog into both memories, release between edges
    task automatic start();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < MEMW; i++) begin
            dut.mem[i] = 32'd0;
            m_mem[i]   = 32'd0;
        end
        for (int i = 0; i < prog.size(); i++) begin
            dut.mem[i] = prog[i];
            m_mem[i]   = prog[i];
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            check("pc", dut.pc, m_pc);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int k, rs, rt, rd;
        logic [15:0] imm;
        k   = int'($urandom_range(0, 11));
        rs  = int'($urandom_range(0, 8));
        rt  = int'($urandom_range(0, 8));
        rd  = int'($urandom_range(0, 8));
        imm = 16'($urandom);
        case (k)
            0: return enc_r(rs, rt, rd, 32);
            1: return enc_r(rs, rt, rd, 34);
            2: return enc_r(rs, rt, rd, 42);
            3: return enc_i(8, rs, rt, imm);
            4: return enc_i(14, rs, rt, imm);
            5: return enc_i(35, 0, rt, 16'(32'h4000 + 4 * $urandom_range(0, 15)));
            6: return enc_i(43, 0, rt, 16'(32'h4000 + 4 * $urandom_range(0, 15)));
            7: return enc_i(4, rs, rt, 16'(int'($urandom_range(0, 8)) - 3));
            8: return enc_i(5, rs, rt, 16'(int'($urandom_range(0, 8)) - 3));
            9: return enc_j(2, int'($urandom_range(0, 47)));
            10: case ($urandom_range(0, 3))
                    0: return enc_r(rs, rt, rd, 36);
                    1: return enc_r(rs, rt, rd, 37);
                    2: return enc_i(12, rs, rt, imm);
                    default: return enc_i(13, rs, rt, imm);
                endcase
            default: return enc_j(3, int'($urandom_range(0, 47)));
        endcase
    endfunction

    logic [31:0] and_exp, or_exp;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
`ifdef CPU_LOGIC_OPS_EN
        and_exp = 32'h000000F0;
        or_exp  = 32'h00000FF0;
`else
        and_exp = 32'd0;
        or_exp  = 32'd0;
`endif
        vecs[0]  = '{enc_r(8, 9, 10, 32),        16'd5,    16'hFFF9, 10, 32'hFFFFFFFE, 32'h0C};
        vecs[1]  = '{enc_r(8, 9, 10, 34),        16'd5,    16'hFFF9, 10, 32'h0000000C, 32'h0C};
        vecs[2]  = '{enc_r(9, 8, 11, 42),        16'd5,    16'hFFFE, 11, 32'd1,        32'h0C};
        vecs[3]  = '{enc_r(8, 9, 11, 42),        16'd5,    16'hFFFE, 11, 32'd0,        32'h0C};
        vecs[4]  = '{enc_i(14, 8, 10, 16'hFFFF), 16'd5,    16'd0,    10, 32'h0000FFFA, 32'h0C};
        vecs[5]  = '{enc_i(8, 0, 0, 16'd1),      16'd5,    16'd0,    0,  32'd0,        32'h0C};
        vecs[6]  = '{enc_i(4, 8, 9, 16'd2),      16'd3,    16'd3,    10, 32'd0,        32'h14};
        vecs[7]  = '{enc_i(5, 8, 9, 16'd2),      16'd3,    16'd3,    10, 32'd0,        32'h0C};
        vecs[8]  = '{enc_i(5, 8, 9, 16'd2),      16'd3,    16'd4,    10, 32'd0,        32'h14};
        vecs[9]  = '{enc_i(63, 0, 10, 16'h1234), 16'd3,    16'd4,    10, 32'd0,        32'h0C};
        vecs[10] = '{enc_r(8, 9, 10, 36),        16'h00F0, 16'h0FF0, 10, and_exp,      32'h0C};
        vecs[11] = '{enc_i(13, 8, 10, 16'h0F00), 16'h00F0, 16'd0,    10, or_exp,       32'h0C};
        vecs[12] = '{enc_r(8, 0, 0, 8),          16'h0040, 16'd0,    8,  32'h00000040, 32'h40};

        // Reset state and first arithmetic
        prog = {enc_i(8, 0, 8, 16'd5), enc_i(8, 8, 9, 16'hFFF9), enc_i(8, 0, 0, 16'd1)};
        start();
        check("reset_pc", dut.pc, 32'd0);
        check("reset_sp", dut.regs[29], 32'h0000FFFC);
        check("reset_r8", dut.regs[8], 32'd0);
        run_cycles(2);
        check("addi_r8", dut.regs[8], 32'd5);
        check("addi_r9", dut.regs[9], 32'hFFFFFFFE);
        run_cycles(1);
        check("r0_zero", dut.regs[0], 32'd0);

        // Directed single-instruction vectors
        for (int v = 0; v < 13; v++) begin
            prog = {enc_i(8, 0, 8, vecs[v].a), enc_i(8, 0, 9, vecs[v].b), vecs[v].instr};
            start();
            run_cycles(3);
            check($sformatf("vec%0d_reg", v), dut.regs[vecs[v].chk], vecs[v].exp_val);
            check($sformatf("vec%0d_pc", v), dut.pc, vecs[v].exp_pc);
        end

        // Branches from PC 0
        prog = {enc_i(4, 0, 0, 16'd2)};
        start();
        run_cycles(1);
        check("beq_pc0", dut.pc, 32'h0C);
        prog = {enc_i(5, 0, 0, 16'd2)};
        start();
        run_cycles(1);
        check("bne_pc0", dut.pc, 32'h04);

        // jal / jr round trip
        prog = {};
        for (int i = 0; i < 17; i++) prog.push_back(32'd0);
        prog[2]  = enc_j(3, 16);
        prog[3]  = enc_i(8, 0, 12, 16'd7);
        prog[16] = enc_r(31, 0, 0, 8);
        start();
        run_cycles(3);
        check("jal_r31", dut.regs[31], 32'h0C);
        check("jal_pc", dut.pc, 32'h40);
        run_cycles(1);
        check("jr_pc", dut.pc, 32'h0C);
        run_cycles(1);
        check("after_jr", dut.regs[12], 32'd7);

        // Store then load, then asynchronous reset mid-program
        prog = {enc_i(8, 0, 8, 16'h4000), enc_i(8, 0, 9, 16'h1234), enc_i(43, 8, 9, 16'd0),
                enc_i(35, 8, 10, 16'd0), enc_i(8, 0, 12, 16'd9)};
        start();
        run_cycles(4);
        check("sw_mem", dut.mem[32'h1000], 32'h00001234);
        check("lw_r10", dut.regs[10], 32'h00001234);
        run_cycles(2);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_pc", dut.pc, 32'd0);
        check("async_r10", dut.regs[10], 32'd0);
        check("async_r12", dut.regs[12], 32'd0);
        check("async_sp", dut.regs[29], 32'h0000FFFC);
        @(negedge clk);
        check("async_mem", dut.mem[32'h1000], 32'h00001234);
        check("held_pc", dut.pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_cycles(1);
        check("restart_r8", dut.regs[8], 32'h00004000);
        run_cycles(4);
        check("restart_r12", dut.regs[12], 32'd9);

        // Recursive Towers of Hanoi, n=5: 2^5-1 moves counted in $v0
        prog = {enc_i(8, 0, 4, 16'd5), enc_i(8, 0, 2, 16'd0), enc_j(3, 4), enc_i(4, 0, 0, 16'hFFFF),
                enc_i(4, 4, 0, 16'd11), enc_i(8, 29, 29, 16'hFFF8), enc_i(43, 29, 31, 16'd4),
                enc_i(43, 29, 4, 16'd0), enc_i(8, 4, 4, 16'hFFFF), enc_j(3, 4),
                enc_i(8, 2, 2, 16'd1), enc_i(35, 29, 4, 16'd0), enc_i(8, 4, 4, 16'hFFFF),
                enc_j(3, 4), enc_i(35, 29, 31, 16'd4), enc_i(8, 29, 29, 16'd8), enc_r(31, 0, 0, 8)};
        start();
        run_cycles(600);
        check("hanoi_v0", dut.regs[2], 32'd31);
        check("hanoi_sp", dut.regs[29], 32'h0000FFFC);
        check("hanoi_pc", dut.pc, 32'h0C);

        // Random programs against the reference model
        for (int p = 0; p < 10; p++) begin
            prog = {};
            for (int r = 1; r <= 8; r++) prog.push_back(enc_i(8, 0, r, 16'($urandom)));
            for (int i = 8; i < 48; i++) prog.push_back(rand_instr());
            start();
            run_cycles(64);
            for (int r = 0; r < 32; r++) check($sformatf("rnd%0d_r%0d", p, r), dut.regs[r], m_regs[r]);
            for (int w = 0; w < 16; w++)
                check($sformatf("rnd%0d_m%0d", p, w), dut.mem[32'h1000 + w], m_mem[32'h1000 + w]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
